// File: rtl/inst_fetch.sv
// inst_fetch: holds the PC, looks it up in a direct-mapped instruction cache and fills misses
// through the memory controller; delivers one instruction per cycle over valid/ready.
module inst_fetch #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_flag,
  input  logic [31:0] mc_inst,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d, mc_addr_q, mc_addr_d, out_inst_q, out_inst_d, out_pc_q, out_pc_d;
  logic               mc_req_q, mc_req_d, out_valid_q, out_valid_d;
  logic [LINES-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   tag_d [LINES];
  logic [31:0]        data_q [LINES];
  logic [31:0]        data_d [LINES];
  logic [IDX_W-1:0]   idx, fill_idx;
  logic               hit, slot_free, miss, fill, load;
  logic [31:0]        redir;
  assign idx       = pc_q[IDX_W+1:2];
  assign fill_idx  = mc_addr_q[IDX_W+1:2];
  assign hit       = vld_q[idx] && tag_q[idx] == pc_q[31:IDX_W+2];
  assign slot_free = !out_valid_q || out_ready;
  assign redir     = redirect_pc & ~32'h3;
  assign miss      = rdy && state_q == IDLE && !redirect && !hit;
  assign fill      = rdy && state_q == WAIT_MEM && mc_flag;
  // A redirect suppresses both the hit path and the fill bypass for this edge.
  assign load      = rdy && !redirect && slot_free &&
                     (state_q == IDLE ? hit : fill && mc_addr_q == pc_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = !rdy               ? state_q  :
              state_q == IDLE    ? (miss ? WAIT_MEM : IDLE) :
              mc_flag            ? IDLE     : WAIT_MEM;
  end
  always_comb begin
    pc_d        = !rdy ? pc_q : redirect ? redir : load ? pc_q + 32'd4 : pc_q;
    out_valid_d = !rdy ? out_valid_q : redirect ? 1'b0 : load ? 1'b1 :
                  (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    out_inst_d  = !load ? out_inst_q : state_q == IDLE ? data_q[idx] : mc_inst;
    out_pc_d    = load ? pc_q : out_pc_q;
    mc_req_d    = miss ? 1'b1 : fill ? 1'b0 : mc_req_q;
    mc_addr_d   = miss ? pc_q : mc_addr_q;
  end
  // The fill always lands in the cache, even when a redirect made it stale.
  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (fill) begin
      vld_d[fill_idx]  = 1'b1;
      tag_d[fill_idx]  = mc_addr_q[31:IDX_W+2];
      data_d[fill_idx] = mc_inst;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      vld_q       <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end
  always_comb begin
    mc_req    = mc_req_q;
    mc_addr   = mc_addr_q;
    out_valid = out_valid_q;
    out_inst  = out_inst_q;
    out_pc    = out_pc_q;
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench; the instruction stream is modelled as "next PC = previous + 4,
// reset or redirect restarts it", and a memory responder tracks which words the cache must hold.
module tb_inst_fetch;
  localparam int IDX_W = 4;
  logic        clk = 1'b0, rst, rdy, mc_req, mc_flag, out_valid, out_ready, redirect;
  logic [31:0] mc_addr, mc_inst, out_inst, out_pc, redirect_pc;
  inst_fetch #(.IDX_W(IDX_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mc_req(mc_req), .mc_addr(mc_addr), .mc_flag(mc_flag),
    .mc_inst(mc_inst), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  int          n_vec = 0, n_err = 0, cycle = 0, n_acc = 0, n_req = 0, lat = -1;
  logic [31:0] exp_q [$];
  logic [31:0] req_log [$];
  int          acc_t [$];
  logic [31:0] mcache [int];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h00000013 : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % (1 << IDX_W));
  endfunction
  function automatic bit logged(input logic [31:0] a, input int k);
    for (int i = k; i < req_log.size(); i++) if (req_log[i] == a) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask
  // Memory controller: one flag per request after a latency, never while rdy is low.
  initial begin : responder
    logic        busy;
    int          cnt;
    logic [31:0] req_addr;
    busy = 0; cnt = 0; req_addr = 0; mc_flag = 0; mc_inst = 0;
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        busy = 0; mc_flag = 0; mcache.delete();
      end else if (mc_flag) begin
        mc_flag = 0;
      end else if (busy) begin
        if (rdy) begin
          if (cnt == 0) begin
            chk("mc_addr stable", mc_addr, req_addr);
            mc_flag = 1; mc_inst = mem(req_addr);
            mcache[line_of(req_addr)] = req_addr;
            busy = 0;
          end else cnt--;
        end
      end else if (mc_req) begin
        busy = 1; req_addr = mc_addr;
        cnt = lat >= 0 ? lat : int'($urandom_range(0, 3));
        req_log.push_back(mc_addr); n_req++;
        chk("miss really uncached", {31'b0, mcache.exists(line_of(mc_addr)) &&
            mcache[line_of(mc_addr)] == mc_addr}, 32'h0);
      end
    end
  end
  // Monitor: checks every accepted instruction against the scoreboard and every hold condition.
  initial begin : monitor
    logic [31:0] p_addr, p_inst, p_pc, e;
    logic        p_req, p_valid, hold_all, hold_out, hold_req;
    hold_all = 0; hold_out = 0; hold_req = 0;
    p_addr = 0; p_inst = 0; p_pc = 0; p_req = 0; p_valid = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst) begin
        if (hold_all) begin
          chk("frozen mc_req", {31'b0, mc_req}, {31'b0, p_req});
          chk("frozen mc_addr", mc_addr, p_addr);
          chk("frozen out_valid", {31'b0, out_valid}, {31'b0, p_valid});
          chk("frozen out_pc", out_pc, p_pc);
          chk("frozen out_inst", out_inst, p_inst);
        end
        if (hold_out) begin
          chk("held out_valid", {31'b0, out_valid}, 32'h1);
          chk("held out_pc", out_pc, p_pc);
          chk("held out_inst", out_inst, p_inst);
        end
        if (hold_req) begin
          chk("held mc_req", {31'b0, mc_req}, 32'h1);
          chk("held mc_addr", mc_addr, p_addr);
        end
      end
      hold_all = !rst && !rdy;
      hold_out = !rst && rdy && out_valid && !out_ready && !redirect;
      hold_req = !rst && rdy && mc_req && !mc_flag;
      p_addr = mc_addr; p_inst = out_inst; p_pc = out_pc; p_req = mc_req; p_valid = out_valid;
      if (!rst && rdy && out_valid && out_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected output: got pc %h, scoreboard empty", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_inst", out_inst, mem(e));
          exp_q.push_back(e + 32'd4);
        end
        n_acc++;
        acc_t.push_back(cycle);
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic redir(input logic [31:0] a);
    redirect = 1; redirect_pc = a;
    exp_q.delete(); exp_q.push_back(a & ~32'h3);
    cyc(1);
    redirect = 0;
  endtask
  task automatic wait_acc(input int target, input string nm);
    int t;
    t = 0;
    while (n_acc < target && t < 400) begin cyc(1); t++; end
    n_vec++;
    if (n_acc < target) begin
      n_err++;
      $display("FAIL %s: got %0d outputs expected %0d", nm, n_acc, target);
    end
  endtask
  task automatic wait_log(input logic [31:0] a, input int k, input string nm);
    int t;
    t = 0;
    while (!logged(a, k) && t < 400) begin cyc(1); t++; end
    n_vec++;
    if (!logged(a, k)) begin
      n_err++;
      $display("FAIL %s: got no request for %h expected one", nm, a);
    end
  endtask
  task automatic wait_req(input logic [31:0] a);
    int t;
    t = 0;
    while (!(mc_req && mc_addr == a) && t < 400) begin cyc(1); t++; end
    chk("request raised", mc_addr, a);
  endtask
  initial begin : driver
    int          k, r0, t0, a0;
    logic [31:0] v, ra;
    rst = 1; rdy = 1; out_ready = 1; redirect = 0; redirect_pc = 0;
    exp_q.push_back(32'h0);
    #1;
    chk("rst mc_req", {31'b0, mc_req}, 32'h0);
    chk("rst mc_addr", mc_addr, 32'h0);
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst out_inst", out_inst, 32'h0);
    chk("rst out_pc", out_pc, 32'h0);
    cyc(2);
    lat = 2;
    rst = 0;
    wait_acc(1, "cold start output");
    wait_log(32'h4, 1, "cold start second request");
    chk("cold first mc_addr", req_log[0], 32'h0);
    chk("cold second mc_addr", req_log[1], 32'h4);
    wait_acc(4, "first pass");
    redir(32'h0);
    wait_acc(5, "second pass start");
    r0 = n_req; t0 = acc_t[$];
    wait_acc(8, "second pass");
    chk("second pass requests", n_req, r0);
    chk("second pass spacing", acc_t[$] - t0, 3);
    out_ready = 0;
    redir(32'h0);
    k = 0;
    while (!out_valid && k < 100) begin cyc(1); k++; end
    cyc(5);
    chk("stall out_valid", {31'b0, out_valid}, 32'h1);
    chk("stall out_pc", out_pc, 32'h0);
    chk("stall out_inst", out_inst, 32'h00000013);
    a0 = n_acc;
    out_ready = 1;
    wait_acc(a0 + 2, "release");
    chk("release spacing", acc_t[$] - acc_t[$-1], 1);
    lat = 6;
    redir(32'h40);
    wait_req(32'h40);
    cyc(1);
    k = req_log.size();
    redir(32'h100);
    lat = 1;
    wait_log(32'h100, k, "request after redirect");
    chk("request after redirect", req_log[k], 32'h100);
    wait_acc(n_acc + 1, "output after redirect");
    k = req_log.size();
    redir(32'h40);
    wait_log(32'h40, k, "alias miss 0x40");
    wait_acc(n_acc + 1, "alias output 0x40");
    k = req_log.size();
    redir(32'h40);
    wait_acc(n_acc + 1, "refetch 0x40");
    chk("0x40 cached", {31'b0, logged(32'h40, k)}, 32'h0);
    k = req_log.size();
    redir(32'h0);
    wait_log(32'h0, k, "alias miss 0x0");
    wait_acc(n_acc + 1, "alias output 0x0");
    redir(32'h0);
    wait_acc(n_acc + 2, "hit stream");
    rdy = 0;
    cyc(1);
    v = out_pc;
    cyc(2);
    chk("rdy low out_pc", out_pc, v);
    rdy = 1;
    wait_acc(n_acc + 2, "resume after rdy");
    lat = 8;
    redir(32'h200);
    wait_req(32'h200);
    cyc(1);
    rst = 1;
    exp_q.delete(); exp_q.push_back(32'h0);
    #1;
    chk("mid-miss rst mc_req", {31'b0, mc_req}, 32'h0);
    chk("mid-miss rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid-miss rst mc_addr", mc_addr, 32'h0);
    cyc(2);
    k = req_log.size();
    lat = 1;
    rst = 0;
    wait_log(32'h0, k, "refetch after reset");
    chk("first request after reset", req_log[k], 32'h0);
    wait_acc(n_acc + 2, "output after reset");
    redir(32'hFFFF_FFFE);
    wait_acc(n_acc + 3, "pc wrap");
    lat = -1;
    a0 = n_acc;
    repeat (3000) begin
      cyc(1);
      out_ready = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) begin
        ra = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 1023));
        redirect = 1; redirect_pc = ra;
        if (rdy) begin exp_q.delete(); exp_q.push_back(ra & ~32'h3); end
      end else redirect = 0;
    end
    redirect = 0; rdy = 1; out_ready = 1;
    cyc(20);
    chk("random phase progress", {31'b0, (n_acc - a0) > 100}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RISCV32I core: holds the PC and looks it up in a direct-mapped instruction cache. On a miss it fetches the word through the memory controller's IF port (`inst_IF_req`/`inst_IF_addr`/`inst_IF_flag`/`inst_IF`). It presents one instruction plus its PC per cycle to the decoder over a valid/ready handshake, and accepts PC redirects from branch resolution.

## Interface
- `IDX_W`, default 4: cache index width; 2^IDX_W lines, one 32-bit word per line.
- `RESET_PC`, default 32'h0: PC loaded at reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rdy`  in  1: global enable; low freezes all state.
- `mc_req`  out  1: fetch request to the memory controller (connects to `inst_IF_req`).
- `mc_addr`  out  32: word address of the request (connects to `inst_IF_addr`).
- `mc_flag`  in  1: one-cycle pulse; `mc_inst` is valid (connects to `inst_IF_flag`).
- `mc_inst`  in  32: fetched instruction word (connects to `inst_IF`).
- `out_valid`  out  1: `out_inst` and `out_pc` hold a fetched instruction.
- `out_inst`  out  32: instruction to the decoder.
- `out_pc`  out  32: PC of `out_inst`.
- `out_ready`  in  1: decoder accepts the instruction this cycle.
- `redirect`  in  1: flush and restart fetch.
- `redirect_pc`  in  32: new PC; bits [1:0] are forced to 0.

## Operation
- **Cache.** Index is `pc[IDX_W+1:2]` and tag is `pc[31:IDX_W+2]`. Each line has a valid bit, a tag and a data word. Lookup is combinational on the current `pc`.
- **Slot free.** The output slot is free when `!out_valid || out_ready`.
- **States.**
  - IDLE:
    - On a hit with the slot free: load `out_inst`/`out_pc`, set `out_valid`=1, `pc += 4`.
    - On a miss: `mc_addr <= pc`, `mc_req <= 1`, go to WAIT_MEM.
    - On a hit with the slot not full-free: hold.
  - WAIT_MEM:
    - Hold `mc_req`=1 and `mc_addr` stable until `mc_flag`.
    - On `mc_flag`:
      - Write the line selected by `mc_addr` (valid=1, tag, `mc_inst`).
      - Set `mc_req <= 0` and go to IDLE.
      - If `mc_addr == pc` and the slot is free, also bypass: load `out_inst=mc_inst`, `out_pc=pc`, `out_valid=1`, `pc += 4`.
- **Consume.** When `out_valid && out_ready` and nothing new is loaded, `out_valid <= 0`.
- **Redirect** (highest priority, any state):
  - `pc <= {redirect_pc[31:2],2'b00}` and `out_valid <= 0`. A simultaneous `out_ready` is ignored.
  - In WAIT_MEM the outstanding request is not aborted. `mc_req`/`mc_addr` stay held, and the returning word is written to the cache. Since `mc_addr != pc`, it is not delivered, unless the redirect target equals `mc_addr`, in which case the bypass delivers it.
  - A redirect in IDLE takes effect at the edge. No lookup is performed that cycle.
- **PC arithmetic.** The PC is 32-bit, and `+4` wraps modulo 2^32.
- **Pause.** When `rdy`=0, no register changes, and outputs hold their values. The memory controller produces no `mc_flag` while `rdy`=0.
- **Controller contract.** The controller ignores `mc_req` in the cycle it pulses `mc_flag`. Each request yields exactly one `mc_flag`.

## Timing
- **Reset values** (asynchronous, immediate):
  - `pc=RESET_PC`, state IDLE.
  - `mc_req=0`, `mc_addr=0`.
  - `out_valid=0`, `out_inst=0`, `out_pc=0`.
  - All cache valid bits 0.
  - Reset mid-miss abandons the request. The controller is reset by the same `rst`.
- **Hit.** A lookup in cycle N gives `out_valid=1` after edge N+1. Throughput is one instruction per cycle while hitting with `out_ready`=1.
- **Miss.**
  - A miss in cycle N gives `mc_req=1` from edge N+1.
  - `mc_flag` in cycle M gives, after edge M+1: line valid, `mc_req=0`, and `out_valid=1` if bypassing.
  - The next sequential PC is looked up in cycle M+1.
- **Backpressure.**
  - `out_valid=1` with `out_ready=0` holds `out_inst`/`out_pc`/`pc` unchanged.
  - A miss fill still completes under backpressure. The instruction is delivered later by hit.
- **Redirect.** In cycle R, `out_valid=0` after edge R+1. The first lookup of the new PC happens in cycle R+1, with `out_valid` at R+2 on a hit.

## Test plan
- Cold start, `RESET_PC=0`, memory returns 32'h00000013 at addr 0 with `mc_flag` 3 cycles after `mc_req`, `out_ready`=1 → `mc_addr=0`; `out_valid` with `out_pc=0`, `out_inst=32'h00000013`; next request `mc_addr=4`.
- Loop of 4 instructions at 0x0–0xC followed by redirect to 0x0 → second pass shows no `mc_req`, with `out_valid` every cycle and PCs 0,4,8,C.
- Hold `out_ready`=0 for 5 cycles with `out_valid`=1 → `out_pc`/`out_inst` stable; after release the next PC follows with no gap on a hit.
- Redirect to 0x100 while WAIT_MEM on 0x40 → the 0x40 word is cached but not output; next `mc_addr=0x100`; the first output has `out_pc=0x100`.
- Aliasing with `IDX_W`=4: fetch 0x000 then redirect to 0x040 (same index, different tag) → miss, line replaced; redirect back to 0x000 misses again.
- Deassert `rdy` for 3 cycles mid-hit stream, and separately assert `rst` during WAIT_MEM → all outputs frozen under `rdy`=0; reset gives immediate `mc_req=0`, `out_valid=0`, and refetch from `RESET_PC` with a cold cache.
